video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the HDMI/DVI output path. It drives
//  active, sync, pixel coordinates and line/frame strobes to the pixel source and TMDS encoder.
//  Successor to the fixed 1024x600 generator; adds:
//  - programmable sync polarity
//  - pixel clock-enable
//  - pixel x/y outputs
//  - line/frame end strobes
//  - frame counter
//  - genlock restart
// PARAMETERS
//  H_ACTIVE    1024  visible pixels per line
//  H_FRONT     48    h front porch, pixels
//  H_SYNC      32    h sync width, pixels
//  H_BACK      266   h back porch, pixels
//  V_ACTIVE    600   visible lines per frame
//  V_FRONT     3     v front porch, lines
//  V_SYNC      6     v sync width, lines
//  V_BACK      21    v back porch, lines
//  H_SYNC_POL  1     h_sync asserted level (1 = active-high, 0 = active-low)
//  V_SYNC_POL  1     v_sync asserted level
//  FRAME_BITS  8     frame_count width
//  Derived: H_TOTAL and V_TOTAL = sum of the four; H_BITS = $clog2(H_TOTAL); V_BITS = $clog2(V_TOTAL).
// PORTS
//  clk          in   1           pixel-domain clock
//  reset        in   1           asynchronous, active-high reset
//  ce           in   1           pixel enable; counters/outputs advance only when 1
//  restart      in   1           genlock: force raster to (0,0)
//  active       out  1           pixel is visible
//  h_sync       out  1           horizontal sync, at H_SYNC_POL when asserted
//  v_sync       out  1           vertical sync, at V_SYNC_POL when asserted
//  h_start      out  1           first pixel of a visible line (1-clk pulse)
//  v_start      out  1           first pixel of the frame (1-clk pulse)
//  line_end     out  1           last pixel of any line (1-clk pulse)
//  frame_end    out  1           last pixel of the frame (1-clk pulse)
//  x            out  H_BITS      h position of the current output pixel
//  y            out  V_BITS      v position of the current output pixel
//  frame_count  out  FRAME_BITS  completed frames, modulo 2^FRAME_BITS
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  Reset values:
//  - h_cnt = v_cnt = 0; x = y = 0; frame_count = 0
//  - active, h_start, v_start, line_end, frame_end = 0
//  - h_sync = ~H_SYNC_POL; v_sync = ~V_SYNC_POL
//  - restart_pend = 0
//  Internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1).
//  Output latency: all outputs are registered decodes of the counter values before the advance,
//  so they lag the counters by 1 clk. x/y equal those pre-advance counters.
//  Decode on a ce=1 cycle:
//  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
//  - h_sync asserted for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC
//  - v_sync asserted for V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC,
//    for every pixel of those lines (not h-aligned)
//  - h_start = (h_cnt == 0) && (v_cnt < V_ACTIVE)
//  - v_start = (h_cnt == 0) && (v_cnt == 0)
//  - line_end = (h_cnt == H_TOTAL-1)
//  - frame_end = line_end && (v_cnt == V_TOTAL-1)
//  Counter advance on ce=1:
//  - h_cnt increments
//  - at H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments
//  - at V_TOTAL-1, v_cnt wraps to 0 and frame_count increments, wrapping naturally
//  ce=0:
//  - counters, active, syncs, x and y hold
//  - h_start, v_start, line_end, frame_end are 0 (strobes are single-clk)
//  restart:
//  - restart=1 with ce=1: the decode uses the current counters as normal, then both counters
//    load 0 instead of advancing, overriding the wrap logic
//  - frame_count increments only on a natural frame wrap
//  - restart=1 with ce=0 sets restart_pend; it is applied and cleared on the next ce=1
//  Reset asserted mid-frame returns everything to the reset values immediately. The first ce
//  after release decodes (0,0), i.e. v_start=1.
//  Parameters must be >= 1. No runtime checking.
// TESTING
//  Small config: H 8/2/2/4 (H_TOTAL 16), V 4/1/1/2 (V_TOTAL 8), polarities 1/0.
//  1. reset, then ce=1 continuous
//     -> 1 clk after release: active=1, v_start=1, h_start=1, x=0, y=0
//     -> active=1 for 8 clks per line on lines 0-3
//     -> frame_end after 128 clks; frame_count=1 one clk later
//  2. h_sync=1 at x=10,11 on every line; v_sync=0 (active-low) on line 5 only, all 16 pixels;
//     line_end at x=15 on every line
//  3. ce toggling 1/0
//     -> raster period doubles to 256 clks
//     -> strobes are 1 clk wide and never asserted on ce=0 cycles
//     -> x/y hold during ce=0
//  4. restart pulse at (x=5, y=2)
//     -> next ce decodes (0,0) with v_start=1
//     -> frame_count unchanged
//     -> restart during ce=0 is applied on the next ce
//  5. FRAME_BITS=2: run 5 frames -> frame_count sequence 1,2,3,0,1
//  6. reset asserted mid-line (x=6, y=1) without clk
//     -> outputs reach reset values asynchronously
//     -> h_sync=0, v_sync=1 (inactive levels)

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: active/sync/strobes, pixel x/y and frame count for the HDMI/DVI path.
// Latency: every output is a registered decode of the pre-advance counters (1 clk behind them).
// Backpressure: none; ce gates advance, outputs hold while ce=0, strobes only on ce=1 cycles.
//
// Ports:
//   clk, reset      pixel clock, asynchronous active-high reset
//   ce              pixel enable; the raster advances only when 1
//   restart         genlock: send the raster back to (0,0), latched if it arrives with ce=0
//   active          pixel lies in the visible area
//   h_sync, v_sync  sync outputs, driven at H_SYNC_POL / V_SYNC_POL while asserted
//   h_start         first pixel of a visible line (1-clk pulse)
//   v_start         first pixel of the frame (1-clk pulse)
//   line_end        last pixel of any line (1-clk pulse)
//   frame_end       last pixel of the frame (1-clk pulse)
//   x, y            coordinates of the pixel being presented
//   frame_count     completed frames, modulo 2^FRAME_BITS
module video_timing_gen #(
    parameter int H_ACTIVE   = 1024,
    parameter int H_FRONT    = 48,
    parameter int H_SYNC     = 32,
    parameter int H_BACK     = 266,
    parameter int V_ACTIVE   = 600,
    parameter int V_FRONT    = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 21,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int FRAME_BITS = 8,
    localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int H_BITS    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
    localparam int V_BITS    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  restart,
    output logic                  active,
    output logic                  h_sync,
    output logic                  v_sync,
    output logic                  h_start,
    output logic                  v_start,
    output logic                  line_end,
    output logic                  frame_end,
    output logic [H_BITS-1:0]     x,
    output logic [V_BITS-1:0]     y,
    output logic [FRAME_BITS-1:0] frame_count
);

    // Counter-width copies of the raster boundaries.
    localparam logic [H_BITS-1:0] H_ACT_END  = H_BITS'(H_ACTIVE);
    localparam logic [H_BITS-1:0] H_SYNC_BEG = H_BITS'(H_ACTIVE + H_FRONT);
    localparam logic [H_BITS-1:0] H_SYNC_END = H_BITS'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(H_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_ACT_END  = V_BITS'(V_ACTIVE);
    localparam logic [V_BITS-1:0] V_SYNC_BEG = V_BITS'(V_ACTIVE + V_FRONT);
    localparam logic [V_BITS-1:0] V_SYNC_END = V_BITS'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(V_TOTAL - 1);

    // Raster state.
    logic [H_BITS-1:0]     h_cnt_q,        h_cnt_d;
    logic [V_BITS-1:0]     v_cnt_q,        v_cnt_d;
    logic [FRAME_BITS-1:0] frame_cnt_q,    frame_cnt_d;
    logic                  restart_pend_q, restart_pend_d;

    // Registered outputs.
    logic                  active_q,    active_d;
    logic                  h_sync_q,    h_sync_d;
    logic                  v_sync_q,    v_sync_d;
    logic                  h_start_q,   h_start_d;
    logic                  v_start_q,   v_start_d;
    logic                  line_end_q,  line_end_d;
    logic                  frame_end_q, frame_end_d;
    logic [H_BITS-1:0]     x_q,         x_d;
    logic [V_BITS-1:0]     y_q,         y_d;
    logic [FRAME_BITS-1:0] frame_out_q, frame_out_d;

    // Decode of the current (pre-advance) counter position.
    logic h_vis, v_vis, h_in_sync, v_in_sync, h_first, h_last, v_last, do_restart;

    always_comb begin
        h_vis      = (h_cnt_q < H_ACT_END);
        v_vis      = (v_cnt_q < V_ACT_END);
        h_in_sync  = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
        v_in_sync  = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
        h_first    = (h_cnt_q == '0);
        h_last     = (h_cnt_q == H_LAST);
        v_last     = (v_cnt_q == V_LAST);
        do_restart = restart || restart_pend_q;
    end

    always_comb begin
        // Hold by default; strobes are single-clock and fall on any non-ce cycle.
        h_cnt_d        = h_cnt_q;
        v_cnt_d        = v_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        restart_pend_d = restart_pend_q;
        active_d       = active_q;
        h_sync_d       = h_sync_q;
        v_sync_d       = v_sync_q;
        x_d            = x_q;
        y_d            = y_q;
        frame_out_d    = frame_out_q;
        h_start_d      = 1'b0;
        v_start_d      = 1'b0;
        line_end_d     = 1'b0;
        frame_end_d    = 1'b0;

        if (ce) begin
            active_d    = h_vis && v_vis;
            h_sync_d    = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_d    = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
            h_start_d   = h_first && v_vis;
            v_start_d   = h_first && (v_cnt_q == '0);
            line_end_d  = h_last;
            frame_end_d = h_last && v_last;
            x_d         = h_cnt_q;
            y_d         = v_cnt_q;
            // The presented count tracks the pixel, so it moves to N+1 together with
            // the first pixel of the next frame rather than with frame_end.
            frame_out_d = frame_cnt_q;

            restart_pend_d = 1'b0;
            if (do_restart) begin
                // Genlock wins over the wrap logic and never counts as a completed frame.
                h_cnt_d = '0;
                v_cnt_d = '0;
            end else if (h_last) begin
                h_cnt_d = '0;
                if (v_last) begin
                    v_cnt_d     = '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end else if (restart) begin
            restart_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            frame_cnt_q    <= '0;
            restart_pend_q <= 1'b0;
            active_q       <= 1'b0;
            h_sync_q       <= ~H_SYNC_POL;
            v_sync_q       <= ~V_SYNC_POL;
            h_start_q      <= 1'b0;
            v_start_q      <= 1'b0;
            line_end_q     <= 1'b0;
            frame_end_q    <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            frame_out_q    <= '0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            restart_pend_q <= restart_pend_d;
            active_q       <= active_d;
            h_sync_q       <= h_sync_d;
            v_sync_q       <= v_sync_d;
            h_start_q      <= h_start_d;
            v_start_q      <= v_start_d;
            line_end_q     <= line_end_d;
            frame_end_q    <= frame_end_d;
            x_q            <= x_d;
            y_q            <= y_d;
            frame_out_q    <= frame_out_d;
        end
    end

    assign active      = active_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign h_start     = h_start_q;
    assign v_start     = v_start_q;
    assign line_end    = line_end_q;
    assign frame_end   = frame_end_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_count = frame_out_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster (H 8/2/2/4, V 4/1/1/2),
// h_sync active-high, v_sync active-low, 2-bit frame counter.
module tb_video_timing_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       restart;
    logic       active, h_sync, v_sync, h_start, v_start, line_end, frame_end;
    logic [3:0] x;
    logic [2:0] y;
    logic [1:0] frame_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vs_last = 0;
    int vs_prev = 0;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .FRAME_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .restart(restart),
        .active(active), .h_sync(h_sync), .v_sync(v_sync),
        .h_start(h_start), .v_start(v_start),
        .line_end(line_end), .frame_end(frame_end),
        .x(x), .y(y), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {active,h_sync,v_sync,h_start,v_start,line_end,frame_end,x,y} at pixel (px,py).
    function automatic logic [13:0] exp_vec(input int px, input int py, input bit strobes);
        logic a, hs, vs, hst, vst, le, fe;
        logic [3:0] ex;
        logic [2:0] ey;
        a   = (px < 8) && (py < 4);
        hs  = (px == 10) || (px == 11);
        vs  = (py != 5);
        hst = strobes && (px == 0) && (py < 4);
        vst = strobes && (px == 0) && (py == 0);
        le  = strobes && (px == 15);
        fe  = le && (py == 7);
        ex  = 4'(px);
        ey  = 3'(py);
        return {a, hs, vs, hst, vst, le, fe, ex, ey};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {active, h_sync, v_sync, h_start, v_start, line_end, frame_end, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (v_start) begin
            vs_prev = vs_last;
            vs_last = cyc;
        end
    endtask

    task automatic check_px(input string tst, input int px, input int py, input int fc);
        chk($sformatf("%s_px(%0d,%0d)", tst, px, py), 32'(obs_vec()), 32'(exp_vec(px, py, 1'b1)));
        chk($sformatf("%s_fc(%0d,%0d)", tst, px, py), 32'(frame_count), 32'(fc));
    endtask

    task automatic check_hold(input string tst, input int px, input int py, input int fc);
        chk($sformatf("%s_hold(%0d,%0d)", tst, px, py), 32'(obs_vec()), 32'(exp_vec(px, py, 1'b0)));
        chk($sformatf("%s_holdfc(%0d,%0d)", tst, px, py), 32'(frame_count), 32'(fc));
    endtask

    // Reset image: everything zero, syncs at their inactive levels (h low, v high).
    localparam logic [13:0] RST_VEC = 14'b0010000_0000_000;

    initial begin
        reset   = 1'b1;
        ce      = 1'b0;
        restart = 1'b0;
        #2;
        chk("reset_vec", 32'(obs_vec()), 32'(RST_VEC));
        chk("reset_fc", 32'(frame_count), 32'd0);

        // Release between edges; first ce edge must present (0,0).
        #10;
        reset = 1'b0;
        ce    = 1'b1;
        tick();
        check_px("t1", 0, 0, 0);

        // Full frame with ce held high: frame_end at the 128th clk, count moves next clk.
        for (int p = 1; p <= 128; p++) begin
            tick();
            check_px("t1", p % 16, (p / 16) % 8, (p < 128) ? 0 : 1);
        end

        // ce toggling: each ce=0 cycle holds the pixel with strobes low.
        for (int p = 1; p <= 128; p++) begin
            ce = 1'b0;
            tick();
            check_hold("t3", (p - 1) % 16, ((p - 1) / 16) % 8, 1);
            ce = 1'b1;
            tick();
            check_px("t3", p % 16, (p / 16) % 8, (p < 128) ? 1 : 2);
        end
        chk("t3_period", 32'(vs_last - vs_prev), 32'd256);

        // Restart with ce=1 while the counters sit at (5,2).
        for (int p = 1; p <= 36; p++) begin
            tick();
            check_px("t4", p % 16, p / 16, 2);
        end
        restart = 1'b1;
        tick();
        check_px("t4_rst", 5, 2, 2);
        restart = 1'b0;
        tick();
        check_px("t4_rst", 0, 0, 2);
        tick();
        check_px("t4", 1, 0, 2);
        tick();
        check_px("t4", 2, 0, 2);

        // Restart during ce=0 is remembered and applied on the next ce.
        ce      = 1'b0;
        restart = 1'b1;
        tick();
        check_hold("t4_pend", 2, 0, 2);
        restart = 1'b0;
        tick();
        check_hold("t4_pend", 2, 0, 2);
        ce = 1'b1;
        tick();
        check_px("t4_pend", 3, 0, 2);
        tick();
        check_px("t4_pend", 0, 0, 2);

        // Three more frames: count runs 2 -> 3 -> 0 -> 1.
        for (int p = 1; p <= 384; p++) begin
            tick();
            check_px("t5", p % 16, (p / 16) % 8, (2 + p / 128) % 4);
        end

        // Asynchronous reset mid-line at (6,1).
        for (int p = 1; p <= 22; p++) begin
            tick();
            check_px("t6", p % 16, p / 16, 1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_vec", 32'(obs_vec()), 32'(RST_VEC));
        chk("t6_async_fc", 32'(frame_count), 32'd0);
        chk("t6_hsync_inactive", 32'(h_sync), 32'd0);
        chk("t6_vsync_inactive", 32'(v_sync), 32'd1);
        tick();
        chk("t6_held_vec", 32'(obs_vec()), 32'(RST_VEC));
        #3;
        reset = 1'b0;
        tick();
        check_px("t6_rel", 0, 0, 0);
        tick();
        check_px("t6_rel", 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
